// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns byte/halfword loads and stores into little-endian
// single-byte data_memory accesses, stalling the pipeline until the response pulse.
module mem_access_ctrl #(
    parameter int ADDR_W = 8,
    parameter int BYTE_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic                req_half,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [2*BYTE_W-1:0] req_wdata,
    output logic                stall,
    output logic                resp_valid,
    output logic [2*BYTE_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0]   dm_addr,
    output logic [BYTE_W-1:0]   dm_wdata,
    output logic                dm_write_en,
    output logic                dm_read,
    input  logic [BYTE_W-1:0]   dm_rdata
);
    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2*BYTE_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic                write_q, write_d, half_q, half_d;
    logic [BYTE_W-1:0]   lo_q, lo_d;

    assign resp_rdata = rdata_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        half_d      = half_q;
        lo_d        = lo_q;
        rdata_d     = rdata_q;
        stall       = 1'b0;
        resp_valid  = 1'b0;
        dm_addr     = '0;
        dm_wdata    = '0;
        dm_write_en = 1'b0;
        dm_read     = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                addr_d  = req_addr;
                wdata_d = req_wdata;
                write_d = req_write;
                half_d  = req_half;
                stall   = 1'b1;
                state_d = LO;
            end
            LO: begin
                stall       = 1'b1;
                dm_addr     = addr_q;
                dm_read     = !write_q;
                dm_write_en = write_q;
                dm_wdata    = write_q ? wdata_q[BYTE_W-1:0] : '0;
                lo_d        = write_q ? lo_q : dm_rdata;
                // a byte access finishes here, so the result is formed straight from the bus
                rdata_d     = half_q ? rdata_q : (write_q ? '0 : {{BYTE_W{1'b0}}, dm_rdata});
                state_d     = half_q ? HI : RESP;
            end
            HI: begin
                stall       = 1'b1;
                dm_addr     = addr_q + ADDR_W'(1);
                dm_read     = !write_q;
                dm_write_en = write_q;
                dm_wdata    = write_q ? wdata_q[2*BYTE_W-1:BYTE_W] : '0;
                rdata_d     = write_q ? '0 : {dm_rdata, lo_q};
                state_d     = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            half_q  <= 1'b0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            half_q  <= half_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized scoreboard bench with a byte-array memory reference model.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, req_half = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        stall, resp_valid, dm_write_en, dm_read;
    logic [15:0] resp_rdata;
    logic [7:0]  dm_addr, dm_wdata, dm_rdata;

    logic [7:0]  ram [256];
    logic [7:0]  ref_mem [256];
    logic [15:0] exp_q [$];
    int          checks = 0, failures = 0, resp_cnt = 0;

    mem_access_ctrl #(.ADDR_W(8), .BYTE_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_half(req_half), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_write_en(dm_write_en),
        .dm_read(dm_read), .dm_rdata(dm_rdata)
    );

    always #5 clk = !clk;

    function automatic logic [7:0] init_byte(int i);
        return i == 100 ? 8'hFE : i == 102 ? 8'h01 : i == 103 ? 8'h01 : i == 119 ? 8'hFF : 8'h00;
    endfunction

    assign dm_rdata = ram[dm_addr];

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = init_byte(i);
        forever begin
            @(posedge clk);
            if (dm_write_en) ram[dm_addr] <= dm_wdata;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (!rst && resp_valid) begin
        resp_cnt++;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL resp_unexpected got=%0h expected=none at %0t", resp_rdata, $time);
        end else check("resp_rdata", 32'(resp_rdata), 32'(exp_q.pop_front()));
    end

    // Called at an IDLE-cycle sample point; returns at the sample point of the following IDLE cycle.
    task automatic issue(input bit w, input bit h, input logic [7:0] a, input logic [15:0] d, input bit keep);
        logic [7:0]  a1 = a + 8'd1;
        logic [15:0] exp;
        int n = 0, act = 0, rd = 0, wr = 0, bad = 0;
        req_valid = 1'b1; req_write = w; req_half = h; req_addr = a; req_wdata = d;
        exp = w ? 16'h0000 : {h ? ref_mem[a1] : 8'h00, ref_mem[a]};
        if (w) begin
            ref_mem[a] = d[7:0];
            if (h) ref_mem[a1] = d[15:8];
        end
        exp_q.push_back(exp);
        #1;
        while (stall && n < 20) begin
            if (n == 0 && (dm_read || dm_write_en)) bad++;
            if (n > 0 && (dm_read || dm_write_en)) begin
                if (dm_read && dm_write_en) bad++;
                if (dm_addr != a + 8'(act)) bad++;
                if (dm_write_en && dm_wdata != (act == 0 ? d[7:0] : d[15:8])) bad++;
                if (dm_read) rd++; else wr++;
                act++;
            end
            n++;
            @(negedge clk); #1;
        end
        if (dm_read || dm_write_en) bad++;
        check("stall_cycles", 32'(n), h ? 32'd3 : 32'd2);
        check("resp_at_latency", 32'(resp_valid), 32'd1);
        check("dm_reads", 32'(rd), w ? 32'd0 : (h ? 32'd2 : 32'd1));
        check("dm_writes", 32'(wr), w ? (h ? 32'd2 : 32'd1) : 32'd0);
        check("dm_protocol_errs", 32'(bad), 32'd0);
        if (!keep) req_valid = 1'b0;
        @(negedge clk); #1;
        check("resp_rdata_hold", 32'(resp_rdata), 32'(exp));
        check("idle_stall", 32'(stall), keep ? 32'd1 : 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", {13'd0, stall, resp_valid, resp_rdata, dm_addr, dm_wdata, dm_write_en, dm_read},
              32'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        issue(0, 1, 8'd100, 16'h0, 0);
        issue(0, 0, 8'd119, 16'h0, 0);
        issue(0, 1, 8'd102, 16'h0, 0);
        issue(1, 1, 8'd255, 16'hBEEF, 0);
        check("ram_255", 32'(ram[255]), 32'hEF);
        check("ram_0_wrap", 32'(ram[0]), 32'hBE);
        issue(0, 1, 8'd255, 16'h0, 0);
        issue(0, 0, 8'd1, 16'h0, 0);
        issue(1, 0, 8'd50, 16'hC35A, 0);
        issue(0, 1, 8'd50, 16'h0, 0);
        base = resp_cnt;
        issue(0, 1, 8'd100, 16'h0, 1);
        issue(0, 1, 8'd102, 16'h0, 0);
        check("back_to_back_resps", 32'(resp_cnt - base), 32'd2);
        base = resp_cnt;
        req_valid = 1'b1; req_write = 1'b1; req_half = 1'b1; req_addr = 8'd10; req_wdata = 16'h1234;
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_outputs", {13'd0, stall, resp_valid, resp_rdata, dm_addr, dm_wdata, dm_write_en, dm_read},
              32'd0);
        ref_mem[10] = 8'h34;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_ram_10", 32'(ram[10]), 32'h34);
        check("abort_ram_11", 32'(ram[11]), 32'(ref_mem[11]));
        check("abort_no_resp", 32'(resp_cnt - base), 32'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        issue(0, 1, 8'd10, 16'h0, 0);
        for (int i = 0; i < 40; i++)
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom),
                  i != 39 && $urandom_range(0, 3) == 0);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        base = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) base++;
        check("ram_vs_model", 32'(base), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
